// File: rtl/sha_mem_pkg.sv
// rtl/sha_mem_pkg.sv - shared types and widths for the SHA-256 memory host
package sha_mem_pkg;

  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 16;
  localparam int HASH_WORDS = 8;

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN} host_state_t;

endpackage

// File: rtl/sha_word_ram.sv
// rtl/sha_word_ram.sv - single-port word RAM, synchronous write, registered read
module sha_word_ram
  import sha_mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              oor
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;

  // Full 16-bit address is range-checked; only in-range accesses touch the array.
  assign oor = {{(32-ADDR_W){1'b0}}, addr} >= 32'(DEPTH);
  assign idx = addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (we && !oor) begin
      mem[idx] <= wdata;
    end
  end

  // Read-before-write: a same-cycle write to idx is not visible here.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= oor ? '0 : mem[idx];
    end
  end

endmodule

// File: rtl/sha256_mem_host.sv
// rtl/sha256_mem_host.sv - loads a message into RAM, serves the SHA-256 engine, drains the digest
module sha256_mem_host
  import sha_mem_pkg::*;
#(
  parameter int          NUM_OF_WORDS = 40,
  parameter int          DEPTH        = 256,
  parameter logic [15:0] INPUT_BASE   = 16'h0000,
  parameter logic [15:0] HASH_BASE    = 16'h0080
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  output logic              eng_start,
  output logic [ADDR_W-1:0] eng_input_addr,
  output logic [ADDR_W-1:0] eng_hash_addr,
  input  logic              eng_done,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_we,
  input  logic [WORD_W-1:0] eng_wdata,
  output logic [WORD_W-1:0] eng_rdata,
  output logic              hash_valid,
  input  logic              hash_ready,
  output logic [WORD_W-1:0] hash_data,
  output logic              hash_last,
  output logic              busy,
  output logic              err
);

  host_state_t state_q, state_d;

  logic [ADDR_W-1:0] load_cnt;
  logic [2:0]        drain_idx;
  logic              hash_valid_q;
  logic              eng_rd_q;
  logic              err_q;

  logic              ram_en, ram_we, ram_oor;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;

  logic load_fire, load_at_end, hash_fire, hash_at_end, err_evt;

  assign load_fire   = (state_q == LOAD) && load_valid;
  assign load_at_end = load_cnt == ADDR_W'(NUM_OF_WORDS - 1);
  assign hash_fire   = (state_q == DRAIN) && hash_valid_q && hash_ready;
  assign hash_at_end = drain_idx == 3'(HASH_WORDS - 1);

  assign eng_input_addr = INPUT_BASE;
  assign eng_hash_addr  = HASH_BASE;

  // The RAM output is shared: it means engine read data only after a RUN-cycle read.
  assign eng_rdata  = eng_rd_q ? ram_rdata : '0;
  assign hash_valid = hash_valid_q;
  assign hash_data  = hash_valid_q ? ram_rdata : '0;
  assign hash_last  = hash_valid_q && hash_at_end;
  assign err        = err_q;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = eng_wdata;
    case (state_q)
      LOAD: begin
        ram_we    = load_valid;
        ram_addr  = INPUT_BASE + load_cnt;
        ram_wdata = load_data;
      end
      RUN: begin
        ram_en   = 1'b1;
        ram_we   = eng_we;
        ram_addr = eng_addr;
      end
      DRAIN: begin
        // Reading only while hash_valid is low keeps hash_data stable under backpressure.
        ram_en   = !hash_valid_q;
        ram_addr = HASH_BASE + ADDR_W'(drain_idx);
      end
      default: ;
    endcase
  end

  assign err_evt = ((ram_en || ram_we) && ram_oor)
                 || (eng_we && (state_q != RUN))
                 || (load_fire && load_at_end && !load_last)
                 || (load_fire && load_last && !load_at_end);

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    eng_start  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (load_valid) state_d = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_fire && (load_at_end || load_last)) state_d = START;
      end
      START: begin
        eng_start = 1'b1;
        if (!eng_done) state_d = RUN;
      end
      RUN: begin
        if (eng_done) state_d = DRAIN;
      end
      DRAIN: begin
        if (hash_fire && hash_at_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      load_cnt     <= '0;
      drain_idx    <= '0;
      hash_valid_q <= 1'b0;
      eng_rd_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q  <= state_d;
      eng_rd_q <= (state_q == RUN);

      if (state_q == IDLE) begin
        load_cnt <= '0;
      end else if (load_fire) begin
        load_cnt <= load_cnt + 1'b1;
      end

      if (state_q == RUN) begin
        drain_idx <= '0;
      end else if (hash_fire) begin
        drain_idx <= drain_idx + 1'b1;
      end

      if ((state_q == DRAIN) && !hash_valid_q) begin
        hash_valid_q <= 1'b1;
      end else if (hash_fire) begin
        hash_valid_q <= 1'b0;
      end

      // Sticky error restarts with each new load.
      if ((state_q == IDLE) && (state_d == LOAD)) begin
        err_q <= err_evt;
      end else if (err_evt) begin
        err_q <= 1'b1;
      end
    end
  end

  sha_word_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata),
    .oor  (ram_oor)
  );

endmodule

// File: tb/tb_sha256_mem_host.sv
// tb/tb_sha256_mem_host.sv - directed bench with an engine BFM driving the memory port
module tb_sha256_mem_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid, load_last;
  logic [31:0] load_data;
  logic        load_ready;
  logic        eng_start;
  logic [15:0] eng_input_addr, eng_hash_addr;
  logic        eng_done;
  logic [15:0] eng_addr;
  logic        eng_we;
  logic [31:0] eng_wdata, eng_rdata;
  logic        hash_valid, hash_ready, hash_last;
  logic [31:0] hash_data;
  logic        busy, err;

  int vectors     = 0;
  int miscompares = 0;
  int start_rises = 0;
  logic start_q = 1'b0;

  sha256_mem_host dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_data     (load_data),
    .load_last     (load_last),
    .eng_start     (eng_start),
    .eng_input_addr(eng_input_addr),
    .eng_hash_addr (eng_hash_addr),
    .eng_done      (eng_done),
    .eng_addr      (eng_addr),
    .eng_we        (eng_we),
    .eng_wdata     (eng_wdata),
    .eng_rdata     (eng_rdata),
    .hash_valid    (hash_valid),
    .hash_ready    (hash_ready),
    .hash_data     (hash_data),
    .hash_last     (hash_last),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (eng_start && !start_q) start_rises <= start_rises + 1;
    start_q <= eng_start;
  end

  // Digest the engine model writes back: SHA-256("abc").
  function automatic logic [31:0] gold(input int k);
    case (k)
      0: return 32'hba7816bf;
      1: return 32'h8f01cfea;
      2: return 32'h414140de;
      3: return 32'h5dae2223;
      4: return 32'hb00361a3;
      5: return 32'h96177a9c;
      6: return 32'hb410ff61;
      7: return 32'hf20015ad;
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_msg(input logic [31:0] base, input int last_idx);
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    load_last  = 1'b0;
    tick();
    chk("load_ready_entry", {31'b0, load_ready}, 32'd1);
    for (int i = 0; i <= last_idx; i++) begin
      load_data = base + 32'(i);
      load_last = (i == last_idx);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic eng_go();
    chk("eng_start_level", {31'b0, eng_start}, 32'd1);
    eng_done = 1'b0;
    tick();
    chk("eng_start_run", {31'b0, eng_start}, 32'd0);
  endtask

  task automatic eng_read(input string tag, input logic [15:0] a, input logic [31:0] exp);
    eng_addr = a;
    tick();
    chk(tag, eng_rdata, exp);
  endtask

  task automatic eng_write_digest(input bit inv);
    for (int k = 0; k < 8; k++) begin
      eng_addr  = 16'h0080 + 16'(k);
      eng_we    = 1'b1;
      eng_wdata = inv ? ~gold(k) : gold(k);
      tick();
    end
    eng_we   = 1'b0;
    eng_done = 1'b1;
    tick();
  endtask

  task automatic drain(input bit inv, input int stall);
    int w;
    logic [31:0] exp;
    for (int k = 0; k < 8; k++) begin
      exp = inv ? ~gold(k) : gold(k);
      w = 0;
      while (!hash_valid && w < 10) begin
        tick();
        w++;
      end
      chk("hash_valid", {31'b0, hash_valid}, 32'd1);
      chk("hash_data", hash_data, exp);
      chk("hash_last", {31'b0, hash_last}, {31'b0, k == 7});
      if (stall == 2 && k == 3) chk("h3_gap", 32'(w), 32'd1);
      if (k == stall) begin
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("stall_valid", {31'b0, hash_valid}, 32'd1);
          chk("stall_data", hash_data, exp);
        end
      end
      hash_ready = 1'b1;
      tick();
      hash_ready = 1'b0;
    end
    chk("drain_done_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    eng_done = 1'b1; eng_addr = '0; eng_we = 1'b0; eng_wdata = '0;
    hash_ready = 1'b0;
    tick();
    tick();
    chk("rst_load_ready", {31'b0, load_ready}, 32'd0);
    chk("rst_eng_start", {31'b0, eng_start}, 32'd0);
    chk("rst_eng_rdata", eng_rdata, 32'd0);
    chk("rst_hash_valid", {31'b0, hash_valid}, 32'd0);
    chk("rst_hash_data", hash_data, 32'd0);
    chk("rst_hash_last", {31'b0, hash_last}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_input_addr", {16'b0, eng_input_addr}, 32'h0000);
    chk("rst_hash_addr", {16'b0, eng_hash_addr}, 32'h0080);
    rst = 1'b0;
    tick();

    // Full 40-word message, then latency check on the engine read port.
    load_msg(32'h0, 39);
    chk("t1_load_ready_off", {31'b0, load_ready}, 32'd0);
    chk("t1_err", {31'b0, err}, 32'd0);
    eng_go();
    for (int i = 0; i < 40; i++) eng_read("t1_rd", 16'(i), 32'(i));
    eng_addr = 16'h0003;
    #1;
    chk("t2_before_edge", eng_rdata, 32'd39);
    tick();
    chk("t2_after_edge", eng_rdata, 32'd3);
    eng_write_digest(1'b0);
    drain(1'b0, -1);
    chk("t1_err_end", {31'b0, err}, 32'd0);
    chk("t1_start_rises", 32'(start_rises), 32'd1);

    // Early last on word 10; tail keeps the previous message, plus H2 backpressure.
    load_msg(32'h1000_0000, 9);
    chk("t3_err", {31'b0, err}, 32'd1);
    eng_go();
    eng_read("t3_word9", 16'd9, 32'h1000_0009);
    eng_read("t3_word10", 16'd10, 32'd10);
    eng_read("t3_word39", 16'd39, 32'd39);
    eng_write_digest(1'b1);
    drain(1'b1, 2);
    chk("t3_err_sticky", {31'b0, err}, 32'd1);

    // Out-of-range write in RUN, then mid-RUN reset and a stray write in IDLE.
    load_msg(32'h2000_0000, 39);
    chk("t6_err_cleared", {31'b0, err}, 32'd0);
    eng_go();
    eng_addr = 16'h0100; eng_we = 1'b1; eng_wdata = 32'hBAD0_BAD0;
    tick();
    eng_we = 1'b0;
    chk("t6_err_oor", {31'b0, err}, 32'd1);
    eng_read("t6_word0_intact", 16'h0000, 32'h2000_0000);
    eng_read("t6_oor_read", 16'h0100, 32'd0);
    rst = 1'b1;
    tick();
    chk("t5_rst_busy", {31'b0, busy}, 32'd0);
    chk("t5_rst_hash_valid", {31'b0, hash_valid}, 32'd0);
    chk("t5_rst_err", {31'b0, err}, 32'd0);
    rst = 1'b0;
    eng_done = 1'b1;
    eng_addr = 16'h0080; eng_we = 1'b1; eng_wdata = 32'h0000_0BAD;
    tick();
    eng_we = 1'b0;
    chk("t6_idle_we_err", {31'b0, err}, 32'd1);
    chk("t6_idle_busy", {31'b0, busy}, 32'd0);

    // Clean run after the reset.
    load_msg(32'h0, 39);
    chk("t5_err_cleared", {31'b0, err}, 32'd0);
    eng_go();
    eng_read("t6_hash0_intact", 16'h0080, ~gold(0));
    eng_read("t5_word7", 16'd7, 32'd7);
    eng_write_digest(1'b0);
    drain(1'b0, -1);
    chk("t5_err_end", {31'b0, err}, 32'd0);
    chk("start_rises_total", 32'(start_rises), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
